mesh_net_iface: RTL and testbench

Network interface (NI) that attaches a local agent (core, L2 slice, memory controller) to the local port of a mesh router.
- Transmit path: packetises agent requests into 256-bit mesh packets with an XY header, buffers them in a TX FIFO, and injects them into the router local input.
- Receive path: accepts ejected packets from the router local output, checks the destination, buffers them in an RX FIFO, and delivers payload plus source coordinates to the agent.
- Forms the endpoint side of the router's valid/ready packet interface.

---
 rtl/mesh_net_iface.sv | 162 ++++++++++++++++
 tb/tb_mesh_net_iface.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_net_iface.sv
// mesh_net_iface: network interface between a local agent and the local port
// of a mesh router.
//   TX path : agent request (dst, payload) -> 256-bit packet with XY header
//             {dst_x, dst_y, src_x, src_y, payload} -> TX FIFO -> router input.
//   RX path : router local output -> destination check -> RX FIFO -> agent.
//             Packets whose destination is not this node are consumed, dropped,
//             and flagged through misroute_err / drop_count.
// Ports:
//   clk, rst                          clock, async active-high reset
//   req_valid/req_ready/req_dst_*/req_payload    agent send request
//   inj_valid/inj_ready/inj_packet               injection toward router
//   ej_valid/ej_ready/ej_packet                  ejection from router
//   resp_valid/resp_ready/resp_src_*/resp_payload delivery to agent
//   misroute_err, tx_count, rx_count, drop_count status and counters
module mesh_net_iface #(
  parameter int X_W      = 4,
  parameter int Y_W      = 4,
  parameter int MY_X     = 0,
  parameter int MY_Y     = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  localparam int PW      = 256 - 2 * (X_W + Y_W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [X_W-1:0] req_dst_x,
  input  logic [Y_W-1:0] req_dst_y,
  input  logic [PW-1:0]  req_payload,
  output logic           inj_valid,
  input  logic           inj_ready,
  output logic [255:0]   inj_packet,
  input  logic           ej_valid,
  output logic           ej_ready,
  input  logic [255:0]   ej_packet,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [X_W-1:0] resp_src_x,
  output logic [Y_W-1:0] resp_src_y,
  output logic [PW-1:0]  resp_payload,
  output logic           misroute_err,
  output logic [31:0]    tx_count,
  output logic [31:0]    rx_count,
  output logic [15:0]    drop_count
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  // RX entries keep only {src_x, src_y, payload}; the destination is implied.
  localparam int RW  = X_W + Y_W + PW;
  localparam logic [X_W-1:0] MY_X_V = X_W'(MY_X);
  localparam logic [Y_W-1:0] MY_Y_V = Y_W'(MY_Y);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [TAW:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RAW:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [31:0]   tx_count_q, tx_count_d, rx_count_q, rx_count_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic          misroute_err_q, misroute_err_d;

  logic [255:0]  tx_mem [TX_DEPTH];
  logic [RW-1:0] rx_mem [RX_DEPTH];
  logic [RW-1:0] rx_head;

  logic tx_empty, tx_full, tx_push, tx_pop;
  logic rx_empty, rx_full, rx_take, rx_hit, rx_push, rx_drop, rx_pop;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) &&
                    (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RAW] != rx_rd_q[RAW]) &&
                    (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);

  // Ready depends only on registered occupancy: a full FIFO refuses a push
  // even when a pop happens in the same cycle.
  assign req_ready  = !tx_full;
  assign inj_valid  = !tx_empty;
  assign inj_packet = tx_mem[tx_rd_q[TAW-1:0]];
  assign tx_push    = req_valid && !tx_full;
  assign tx_pop     = !tx_empty && inj_ready;

  assign ej_ready = !rx_full;
  assign rx_take  = ej_valid && !rx_full;
  assign rx_hit   = (ej_packet[255 -: X_W] == MY_X_V) &&
                    (ej_packet[255 - X_W -: Y_W] == MY_Y_V);
  // Misrouted packets are still handshaken; they just never reach the FIFO.
  assign rx_push  = rx_take && rx_hit;
  assign rx_drop  = rx_take && !rx_hit;
  assign rx_pop   = !rx_empty && resp_ready;

  assign resp_valid   = !rx_empty;
  assign rx_head      = rx_mem[rx_rd_q[RAW-1:0]];
  assign resp_src_x   = rx_head[RW-1 -: X_W];
  assign resp_src_y   = rx_head[PW+Y_W-1 -: Y_W];
  assign resp_payload = rx_head[PW-1:0];

  assign misroute_err = misroute_err_q;
  assign tx_count     = tx_count_q;
  assign rx_count     = rx_count_q;
  assign drop_count   = drop_count_q;

  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    tx_wr_d        = tx_wr_q;
    tx_rd_d        = tx_rd_q;
    rx_wr_d        = rx_wr_q;
    rx_rd_d        = rx_rd_q;
    tx_count_d     = tx_count_q;
    rx_count_d     = rx_count_q;
    drop_count_d   = drop_count_q;
    misroute_err_d = misroute_err_q;

    if (tx_push) tx_wr_d = tx_wr_q + (TAW+1)'(1);
    if (tx_pop) begin
      tx_rd_d    = tx_rd_q + (TAW+1)'(1);
      tx_count_d = tx_count_q + 32'd1;
    end
    if (rx_push) rx_wr_d = rx_wr_q + (RAW+1)'(1);
    if (rx_pop) begin
      rx_rd_d    = rx_rd_q + (RAW+1)'(1);
      rx_count_d = rx_count_q + 32'd1;
    end
    if (rx_drop) begin
      misroute_err_d = 1'b1;
      if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_q        <= '0;
      tx_rd_q        <= '0;
      rx_wr_q        <= '0;
      rx_rd_q        <= '0;
      tx_count_q     <= '0;
      rx_count_q     <= '0;
      drop_count_q   <= '0;
      misroute_err_q <= 1'b0;
    end else begin
      tx_wr_q        <= tx_wr_d;
      tx_rd_q        <= tx_rd_d;
      rx_wr_q        <= rx_wr_d;
      rx_rd_q        <= rx_rd_d;
      tx_count_q     <= tx_count_d;
      rx_count_q     <= rx_count_d;
      drop_count_q   <= drop_count_d;
      misroute_err_q <= misroute_err_d;
    end
  end

  // NOTE: storage arrays are not reset; reset empties the FIFOs through the
  // pointers, and stale entries are never presented while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[TAW-1:0]] <= {req_dst_x, req_dst_y, MY_X_V, MY_Y_V, req_payload};
    if (rx_push) rx_mem[rx_wr_q[RAW-1:0]] <= ej_packet[RW-1:0];
  end

endmodule

// File: tb/tb_mesh_net_iface.sv
// Self-checking bench for mesh_net_iface (node at X=1, Y=2).
// Directed scenarios plus a randomized phase; a negedge monitor compares the
// DUT against a queue-based reference model of both FIFO paths and counters.
module tb_mesh_net_iface;

  localparam int DEPTH = 4;
  localparam logic [3:0] NX = 4'd1;
  localparam logic [3:0] NY = 4'd2;

  logic         clk, rst;
  logic         req_valid, req_ready;
  logic [3:0]   req_dst_x, req_dst_y;
  logic [239:0] req_payload;
  logic         inj_valid, inj_ready;
  logic [255:0] inj_packet;
  logic         ej_valid, ej_ready;
  logic [255:0] ej_packet;
  logic         resp_valid, resp_ready;
  logic [3:0]   resp_src_x, resp_src_y;
  logic [239:0] resp_payload;
  logic         misroute_err;
  logic [31:0]  tx_count, rx_count;
  logic [15:0]  drop_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: packets in flight, entries awaiting delivery, counters.
  logic [255:0] tx_q[$];
  logic [247:0] rx_q[$];
  logic [31:0]  m_tx, m_rx;
  logic [15:0]  m_drop;
  logic         m_err;

  mesh_net_iface #(
    .X_W(4), .Y_W(4), .MY_X(1), .MY_Y(2), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_payload(req_payload),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_packet(inj_packet),
    .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_packet(ej_packet),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_src_x(resp_src_x), .resp_src_y(resp_src_y), .resp_payload(resp_payload),
    .misroute_err(misroute_err), .tx_count(tx_count), .rx_count(rx_count),
    .drop_count(drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [239:0] rand_pl();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r[239:0];
  endfunction

  function automatic logic [255:0] mk_pkt(input logic [3:0] dx, input logic [3:0] dy,
                                          input logic [3:0] sx, input logic [3:0] sy,
                                          input logic [239:0] pl);
    return {dx, dy, sx, sy, pl};
  endfunction

  // Monitor / scoreboard. At each negedge the model reflects every handshake
  // up to the previous rising edge; then the handshakes that the coming edge
  // will complete are applied to the model.
  always @(negedge clk) begin
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      m_tx = '0; m_rx = '0; m_drop = '0; m_err = 1'b0;
    end else begin
      check("req_ready",    req_ready,  tx_q.size() < DEPTH);
      check("inj_valid",    inj_valid,  tx_q.size() != 0);
      check("ej_ready",     ej_ready,   rx_q.size() < DEPTH);
      check("resp_valid",   resp_valid, rx_q.size() != 0);
      check("tx_count",     tx_count,   m_tx);
      check("rx_count",     rx_count,   m_rx);
      check("drop_count",   drop_count, m_drop);
      check("misroute_err", misroute_err, m_err);
      // Head is compared every cycle it is valid, which also covers stability
      // while the consumer stalls.
      if (inj_valid && tx_q.size() != 0) check("inj_packet", inj_packet, tx_q[0]);
      if (resp_valid && rx_q.size() != 0)
        check("resp_entry", {resp_src_x, resp_src_y, resp_payload}, rx_q[0]);

      if (inj_valid && inj_ready && tx_q.size() != 0) begin
        void'(tx_q.pop_front());
        m_tx++;
      end
      if (req_valid && req_ready)
        tx_q.push_back({req_dst_x, req_dst_y, NX, NY, req_payload});
      if (resp_valid && resp_ready && rx_q.size() != 0) begin
        void'(rx_q.pop_front());
        m_rx++;
      end
      if (ej_valid && ej_ready) begin
        if (ej_packet[255:252] == NX && ej_packet[251:248] == NY)
          rx_q.push_back(ej_packet[247:0]);
        else begin
          m_err = 1'b1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
      end
    end
  end

  // Driver tasks are entered and left 1 time unit after a rising edge.
  task automatic send(input logic [3:0] dx, input logic [3:0] dy, input logic [239:0] pl);
    int n = 0;
    req_valid = 1'b1; req_dst_x = dx; req_dst_y = dy; req_payload = pl;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic eject(input logic [255:0] pkt);
    int n = 0;
    ej_valid = 1'b1; ej_packet = pkt;
    @(negedge clk);
    while (!ej_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ej_accept", ej_ready, 1'b1);
    @(posedge clk);
    #1 ej_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 0; req_dst_x = 0; req_dst_y = 0; req_payload = 0;
    inj_ready = 0; ej_valid = 0; ej_packet = 0; resp_ready = 0;
    #1;
    check("rst_req_ready",  req_ready, 1'b1);
    check("rst_ej_ready",   ej_ready,  1'b1);
    check("rst_inj_valid",  inj_valid, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_counts", {tx_count, rx_count, drop_count, misroute_err}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single send: header {dst=(3,0), src=(1,2)} visible the cycle after accept.
    inj_ready = 1'b1;
    send(4'd3, 4'd0, 240'hABCD);
    check("t1_inj_valid",   inj_valid, 1'b1);
    check("t1_header",      inj_packet[255:240], 16'h3012);
    check("t1_payload",     inj_packet[239:0], 240'hABCD);
    cycles(2);
    check("t1_tx_count",    tx_count, 32'd1);

    // TX backpressure: four fill the FIFO, the fifth waits for space.
    inj_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'(i), 4'(i + 1), 240'(100 + i));
    check("t2_full_req_ready", req_ready, 1'b0);
    fork
      begin cycles(3); inj_ready = 1'b1; end
      send(4'd7, 4'd7, 240'd104);
    join
    cycles(10);
    check("t2_tx_count", tx_count, 32'd6);

    // RX deliver: one-cycle latency to resp_valid.
    eject(mk_pkt(NX, NY, 4'd0, 4'd3, 240'h55));
    check("t3_resp_valid", resp_valid, 1'b1);
    check("t3_resp", {resp_src_x, resp_src_y, resp_payload}, {4'd0, 4'd3, 240'h55});
    resp_ready = 1'b1;
    cycles(1);
    resp_ready = 1'b0;
    check("t3_rx_count", rx_count, 32'd1);

    // Misroute: consumed, dropped, flagged.
    eject(mk_pkt(4'd2, 4'd2, 4'd5, 4'd5, 240'h77));
    check("t4_resp_valid", resp_valid, 1'b0);
    check("t4_err",        misroute_err, 1'b1);
    check("t4_drop",       drop_count, 16'd1);

    // RX full, then streaming across pointer wrap (rx_count ends at 1 + 14).
    for (int i = 0; i < 4; i++) eject(mk_pkt(NX, NY, 4'(i), 4'(9 - i), rand_pl()));
    check("t5_full_ej_ready", ej_ready, 1'b0);
    resp_ready = 1'b1;
    for (int i = 0; i < 10; i++) eject(mk_pkt(NX, NY, 4'(i + 3), 4'(i), rand_pl()));
    cycles(3);
    check("t5_rx_count", rx_count, 32'd15);
    check("t5_drained",  resp_valid, 1'b0);

    // Randomized traffic on both paths with random backpressure.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          cycles($urandom_range(0, 3));
          send(4'($urandom), 4'($urandom), rand_pl());
        end
      end
      begin
        for (int i = 0; i < 60; i++) begin
          logic [3:0] dx, dy;
          cycles($urandom_range(0, 3));
          dx = NX; dy = NY;
          if ($urandom_range(0, 3) == 0) begin dx = 4'($urandom); dy = 4'($urandom); end
          eject(mk_pkt(dx, dy, 4'($urandom), 4'($urandom), rand_pl()));
        end
      end
      begin
        for (int i = 0; i < 400; i++) begin
          cycles(1);
          inj_ready  = 1'($urandom);
          resp_ready = 1'($urandom);
        end
        inj_ready = 1'b1; resp_ready = 1'b1;
      end
    join
    inj_ready = 1'b1; resp_ready = 1'b1;
    cycles(20);
    check("rnd_tx_drained", inj_valid, 1'b0);

    // Async reset mid-stream with 3 TX and 2 RX entries pending.
    inj_ready = 1'b0; resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'(i), 4'd1, rand_pl());
    for (int i = 0; i < 2; i++) eject(mk_pkt(NX, NY, 4'(i), 4'd4, rand_pl()));
    check("t6_pending_tx", inj_valid,  1'b1);
    check("t6_pending_rx", resp_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_inj_valid",  inj_valid,  1'b0);
    check("t6_resp_valid", resp_valid, 1'b0);
    check("t6_counts", {tx_count, rx_count, drop_count, misroute_err}, '0);
    check("t6_readies", {req_ready, ej_ready}, 2'b11);
    @(negedge clk);
    #1 rst = 1'b0;
    cycles(1);
    inj_ready = 1'b1;
    send(4'd1, 4'd2, 240'h5E1F);
    cycles(3);
    check("t6_post_tx_count", tx_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
